counter_loader: RTL and testbench

- Host-side writer for the 8-bit loadable free-running counter. Accepts queued load commands, drives the counter's `wr`/`wdata` load port, then reads back the counter's `data` after a programmed delay.
- Checks that the counter reached the expected value and reports pass or fail.
- Sits between a command source (valid/ready) and the counter instance. Used for bring-up self-check and programmed phase alignment.

---
 rtl/counter_loader.sv | 199 +++++++++++++++++++
 tb/tb_counter_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_loader.sv
// counter_loader: queues load commands, loads the counter, then checks its readback after a delay.
// Build option: define COUNTER_LOADER_RETRY_EN for one retry per command plus a retry_count output.

module counter_loader #(
    parameter int W          = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int WAIT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W-1:0]      cmd_value,
    input  logic [WAIT_W-1:0] cmd_wait,
    output logic              wr,
    output logic [W-1:0]      wdata,
    input  logic [W-1:0]      cnt_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [W-1:0]      err_value,
    output logic [7:0]        err_count
`ifdef COUNTER_LOADER_RETRY_EN
    ,
    output logic [7:0]        retry_count
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [W-1:0]      val_mem  [FIFO_DEPTH];
    logic [WAIT_W-1:0] wait_mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       count_q, count_d;
    logic              push, pop;

    logic [W-1:0]      wdata_q, wdata_d;
    logic [WAIT_W-1:0] nwait_q, nwait_d;
    logic [WAIT_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [W-1:0]      err_value_q, err_value_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              busy_q, busy_d;
    logic [W-1:0]      expect_val;
    logic              fail;
`ifdef COUNTER_LOADER_RETRY_EN
    logic              retried_q, retried_d;
    logic [7:0]        retry_count_q, retry_count_d;
`endif

    assign cmd_ready  = (count_q != FULL);
    assign push       = cmd_valid && cmd_ready;
    // wdata_q carries V for the whole command, so the expected value is derived from it.
    assign expect_val = wdata_q + W'(nwait_q);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        nwait_d     = nwait_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_value_d = err_value_q;
        err_count_d = err_count_q;
        pop         = 1'b0;
        fail        = 1'b0;
`ifdef COUNTER_LOADER_RETRY_EN
        retried_d     = retried_q;
        retry_count_d = retry_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    wdata_d = val_mem[rptr_q];
                    nwait_d = wait_mem[rptr_q];
                    state_d = S_LOAD;
`ifdef COUNTER_LOADER_RETRY_EN
                    retried_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                rem_d   = nwait_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - WAIT_W'(1);
                end else begin
                    state_d = S_IDLE;
                    if (cnt_data == expect_val) begin
                        done_d = 1'b1;
`ifdef COUNTER_LOADER_RETRY_EN
                        if (retried_q && (retry_count_q != 8'hFF))
                            retry_count_d = retry_count_q + 8'd1;
`endif
                    end else begin
`ifdef COUNTER_LOADER_RETRY_EN
                        if (!retried_q) begin
                            retried_d = 1'b1;
                            state_d   = S_LOAD;
                        end else begin
                            fail = 1'b1;
                        end
`else
                        fail = 1'b1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            err_d       = 1'b1;
            err_value_d = cnt_data;
            if (err_count_q != 8'hFF)
                err_count_d = err_count_q + 8'd1;
        end
        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            val_mem[wptr_q]  <= cmd_value;
            wait_mem[wptr_q] <= cmd_wait;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wdata_q     <= '0;
            nwait_q     <= '0;
            rem_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_value_q <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
`ifdef COUNTER_LOADER_RETRY_EN
            retried_q     <= 1'b0;
            retry_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wdata_q     <= wdata_d;
            nwait_q     <= nwait_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_value_q <= err_value_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
`ifdef COUNTER_LOADER_RETRY_EN
            retried_q     <= retried_d;
            retry_count_q <= retry_count_d;
`endif
        end
    end

    assign wr        = (state_q == S_LOAD);
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_value = err_value_q;
    assign err_count = err_count_q;
`ifdef COUNTER_LOADER_RETRY_EN
    assign retry_count = retry_count_q;
`endif

endmodule

// File: tb/tb_counter_loader.sv
// Bench for counter_loader with a behavioural loadable counter attached and a fault-injection mux.
// Honours COUNTER_LOADER_RETRY_EN for the retry expectations.

module tb_counter_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_value = '0;
    logic [7:0] cmd_wait = '0;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] cnt_data;
    logic       busy, done, err;
    logic [7:0] err_value, err_count;
    logic [7:0] rc_obs;
`ifdef COUNTER_LOADER_RETRY_EN
    logic [7:0] retry_count;
    assign rc_obs = retry_count;
`else
    assign rc_obs = 8'd0;
`endif

    counter_loader #(.W(8), .FIFO_DEPTH(4), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_value(cmd_value), .cmd_wait(cmd_wait), .wr(wr), .wdata(wdata),
        .cnt_data(cnt_data), .busy(busy), .done(done), .err(err),
        .err_value(err_value), .err_count(err_count)
`ifdef COUNTER_LOADER_RETRY_EN
        , .retry_count(retry_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural counter: load on wr, otherwise free-run; fault forces the readback.
    logic [7:0] cnt_q = 8'd0;
    logic       fault = 1'b0;
    always @(posedge clk) cnt_q <= wr ? wdata : cnt_q + 8'd1;
    assign cnt_data = fault ? 8'hAA : cnt_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] data; } wr_ev_t;
    typedef struct { int cyc; logic d; logic e; logic [7:0] ev; logic [7:0] ec; logic [7:0] rc; logic [7:0] seen; } cpl_ev_t;
    typedef struct { logic [7:0] v; logic [7:0] n; logic exp_err; } exp_t;

    wr_ev_t  wr_log[$];
    cpl_ev_t cpl_log[$];
    exp_t    sb[$];
    logic [7:0] prev_cnt = '0;

    always @(negedge clk) begin
        if (wr === 1'b1) wr_log.push_back('{cyc, wdata});
        if (done === 1'b1 || err === 1'b1)
            cpl_log.push_back('{cyc, done, err, err_value, err_count, rc_obs, prev_cnt});
        prev_cnt = cnt_data;
    end

    int checks = 0;
    int failures = 0;

    task automatic clear_logs();
        wr_log.delete();
        cpl_log.delete();
        sb.delete();
    endtask

    task automatic push_cmd(input logic [7:0] v, input logic [7:0] n, input logic exp_err, output int acc_cyc);
        cmd_value = v;
        cmd_wait  = n;
        cmd_valid = 1'b1;
        acc_cyc   = -1;
        for (int i = 0; i < 200 && acc_cyc < 0; i++) begin
            if (cmd_ready === 1'b1) begin
                acc_cyc = cyc;
                sb.push_back('{v, n, exp_err});
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (acc_cyc < 0) begin
            failures++;
            $display("FAIL push_accept value=%h got=not_accepted exp=accepted", v);
        end
    endtask

    task automatic wait_cpl(input int n);
        for (int i = 0; i < 400 && cpl_log.size() < n; i++) @(negedge clk);
        checks++;
        if (cpl_log.size() < n) begin
            failures++;
            $display("FAIL cpl_timeout got=%0d exp=%0d", cpl_log.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wr !== 1'b0)        begin failures++; $display("FAIL reset_wr got=%b exp=0", wr); end
        checks++; if (wdata !== 8'h00)    begin failures++; $display("FAIL reset_wdata got=%h exp=00", wdata); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (err_value !== 8'h00) begin failures++; $display("FAIL reset_err_value got=%h exp=00", err_value); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL reset_err_count got=%h exp=00", err_count); end
        checks++; if (rc_obs !== 8'h00)   begin failures++; $display("FAIL reset_retry_count got=%h exp=00", rc_obs); end
        clear_logs();
        repeat (6) @(negedge clk);
        checks++; if (wr_log.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL idle_quiet got=wr%0d_busy%b exp=wr0_busy0", wr_log.size(), busy); end
    endtask

    task automatic test_load(input logic [7:0] v, input logic [7:0] n);
        int acc;
        exp_t e;
        wr_ev_t w;
        cpl_ev_t c;
        logic [7:0] expv;
        logic [7:0] ec0;
        clear_logs();
        ec0 = err_count;
        push_cmd(v, n, 1'b0, acc);
        wait_cpl(1);
        repeat (3) @(negedge clk);
        if (sb.size() > 0 && wr_log.size() > 0 && cpl_log.size() > 0) begin
            e = sb.pop_front();
            w = wr_log.pop_front();
            c = cpl_log.pop_front();
            expv = e.v + e.n;
            checks++; if (w.data !== e.v) begin failures++; $display("FAIL load_wdata got=%h exp=%h", w.data, e.v); end
            checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL load_wr_width got=%0d exp=1", wr_log.size() + 1); end
            checks++; if (c.seen !== expv) begin failures++; $display("FAIL load_readback got=%h exp=%h", c.seen, expv); end
            checks++; if (c.cyc - w.cyc != 2 + int'(n)) begin failures++; $display("FAIL load_latency got=%0d exp=%0d", c.cyc - w.cyc, 2 + int'(n)); end
            checks++; if (c.d !== 1'b1 || c.e !== 1'b0) begin failures++; $display("FAIL load_done got=d%b_e%b exp=d1_e0", c.d, c.e); end
            checks++; if (cpl_log.size() != 0) begin failures++; $display("FAIL load_done_width got=%0d exp=1", cpl_log.size() + 1); end
            checks++; if (c.ec !== ec0) begin failures++; $display("FAIL load_err_count got=%h exp=%h", c.ec, ec0); end
            checks++; if (wdata !== v || busy !== 1'b0) begin failures++; $display("FAIL load_hold got=%h_busy%b exp=%h_busy0", wdata, busy, v); end
        end
    endtask

    task automatic test_fault();
        int acc;
        exp_t e;
        wr_ev_t w;
        cpl_ev_t c;
        clear_logs();
`ifdef COUNTER_LOADER_RETRY_EN
        push_cmd(8'h00, 8'h02, 1'b0, acc);
`else
        push_cmd(8'h00, 8'h02, 1'b1, acc);
`endif
        for (int i = 0; i < 50 && wr !== 1'b1; i++) @(negedge clk);
        if (wr === 1'b1) begin
            repeat (3) @(posedge clk);
            #1 fault = 1'b1;
            @(posedge clk);
            #1 fault = 1'b0;
        end
        wait_cpl(1);
        repeat (3) @(negedge clk);
        if (sb.size() > 0 && wr_log.size() > 0 && cpl_log.size() > 0) begin
            e = sb.pop_front();
            w = wr_log.pop_front();
            c = cpl_log.pop_front();
            checks++; if (c.e !== e.exp_err || c.d === e.exp_err) begin failures++; $display("FAIL fault_flags got=d%b_e%b exp_err=%b", c.d, c.e, e.exp_err); end
`ifdef COUNTER_LOADER_RETRY_EN
            checks++; if (wr_log.size() != 1) begin failures++; $display("FAIL retry_wr_count got=%0d exp=2", wr_log.size() + 1); end
            if (wr_log.size() > 0) begin
                checks++; if (wr_log[0].cyc - w.cyc != 4) begin failures++; $display("FAIL retry_reload_gap got=%0d exp=4", wr_log[0].cyc - w.cyc); end
                checks++; if (c.cyc - wr_log[0].cyc != 4) begin failures++; $display("FAIL retry_latency got=%0d exp=4", c.cyc - wr_log[0].cyc); end
            end
            checks++; if (c.ec !== 8'd0) begin failures++; $display("FAIL retry_err_count got=%h exp=00", c.ec); end
            checks++; if (c.rc !== 8'd1) begin failures++; $display("FAIL retry_count got=%h exp=01", c.rc); end
`else
            checks++; if (c.ev !== 8'hAA || err_value !== 8'hAA) begin failures++; $display("FAIL fault_err_value got=%h/%h exp=aa", c.ev, err_value); end
            checks++; if (c.ec !== 8'd1 || err_count !== 8'd1) begin failures++; $display("FAIL fault_err_count got=%h/%h exp=01", c.ec, err_count); end
            checks++; if (c.cyc - w.cyc != 4) begin failures++; $display("FAIL fault_latency got=%0d exp=4", c.cyc - w.cyc); end
            checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL fault_wr_count got=%0d exp=1", wr_log.size() + 1); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int acc[5];
        int acc0;
        int nexp;
        logic [7:0] ec0;
        clear_logs();
        ec0 = err_count;
        push_cmd(8'h40, 8'd20, 1'b0, acc0);
        for (int i = 0; i < 50 && wr !== 1'b1; i++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            push_cmd(8'h80 + 8'(k), 8'd0, 1'b0, acc[k]);
            if (k == 3) begin
                checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", cmd_ready); end
            end
        end
        checks++; if (acc[4] - acc[3] <= 1) begin failures++; $display("FAIL b2b_backpressure got=%0d exp=>1", acc[4] - acc[3]); end
        wait_cpl(6);
        repeat (3) @(negedge clk);
        nexp = 6;
        checks++; if (wr_log.size() != nexp || cpl_log.size() != nexp || sb.size() != nexp) begin
            failures++; $display("FAIL b2b_counts got=wr%0d_cpl%0d exp=6", wr_log.size(), cpl_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (wr_log[i].data !== sb[i].v) begin failures++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, wr_log[i].data, sb[i].v); end
                checks++; if (cpl_log[i].d !== 1'b1 || cpl_log[i].e !== 1'b0 || cpl_log[i].ec !== ec0) begin
                    failures++; $display("FAIL b2b_result idx=%0d got=d%b_e%b_ec%h exp=d1_e0_ec%h", i, cpl_log[i].d, cpl_log[i].e, cpl_log[i].ec, ec0);
                end
                checks++; if (cpl_log[i].cyc - wr_log[i].cyc != 2 + int'(sb[i].n)) begin
                    failures++; $display("FAIL b2b_latency idx=%0d got=%0d exp=%0d", i, cpl_log[i].cyc - wr_log[i].cyc, 2 + int'(sb[i].n));
                end
                if (i > 0) begin
                    checks++; if (wr_log[i].cyc - wr_log[i-1].cyc != 3 + int'(sb[i-1].n)) begin
                        failures++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", i, wr_log[i].cyc - wr_log[i-1].cyc, 3 + int'(sb[i-1].n));
                    end
                end
            end
        end
        clear_logs();
    endtask

    task automatic test_reset_mid();
        int acc;
        exp_t e;
        cpl_ev_t c;
        clear_logs();
        push_cmd(8'h11, 8'd10, 1'b0, acc);
        push_cmd(8'h22, 8'd10, 1'b0, acc);
        push_cmd(8'h33, 8'd1, 1'b0, acc);
        push_cmd(8'h44, 8'd1, 1'b0, acc);
        for (int i = 0; i < 200 && wr_log.size() < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (cpl_log.size() != 1 || sb.size() != 4) begin
            failures++; $display("FAIL rst_pre_cpl got=%0d exp=1", cpl_log.size());
        end else begin
            e = sb.pop_front();
            c = cpl_log.pop_front();
            checks++; if (c.d !== 1'b1 || c.seen !== e.v + e.n) begin failures++; $display("FAIL rst_first_cmd got=d%b_%h exp=d1_%h", c.d, c.seen, e.v + e.n); end
        end
        clear_logs();
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_state got=busy%b_ready%b exp=busy0_ready1", busy, cmd_ready); end
        checks++; if (err_count !== 8'd0 || err_value !== 8'd0) begin failures++; $display("FAIL rst_err_regs got=%h_%h exp=00_00", err_count, err_value); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_fifo_empty got=busy%b exp=busy0", busy); end
        repeat (30) @(negedge clk);
        checks++; if (wr_log.size() != 0 || cpl_log.size() != 0) begin
            failures++; $display("FAIL rst_discard got=wr%0d_cpl%0d exp=wr0_cpl0", wr_log.size(), cpl_log.size());
        end
        test_load(8'h55, 8'd4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load(8'h10, 8'd5);
        test_load(8'hFE, 8'd3);
        test_load(8'h7F, 8'd0);
        test_fault();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
